// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: multiplexed 7-segment/LED digit scanner.
//
// Cycles through NUM_DIG digits, SCAN_DIV clocks per digit slot. Each slot starts with GUARD dark
// clocks so the previous digit's segments never ghost onto the next enable. Brightness is a 15-step
// PWM restarted at every slot. Digits can be blanked or made to blink at a rate of BLINK_DIV frames
// per half-period. New display contents are loaded into a staging set and committed to the active
// set only at a frame boundary, so a frame is never shown half old and half new.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   display_in   NUM_DIG segment bytes, active-low, digit 0 in the most significant byte
//   blank_mask   per-digit force dark, bit NUM_DIG-1 = digit 0
//   blink_mask   per-digit blink enable, bit NUM_DIG-1 = digit 0
//   bright       PWM duty 0..15 (15 = always on), used live
//   load         capture display_in / masks into staging
//   load_ack     one-clock pulse when staging is committed to the active set
//   frame_start  one-clock pulse when the digit index wraps to 0
//   led_en       digit enables, active-low, bit NUM_DIG-1 = digit 0
//   led_cx       segment outputs, active-low
module led_scan_ctrl #(
  parameter int unsigned NUM_DIG   = 8,
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned GUARD     = 2,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_DIG*8-1:0]   display_in,
  input  logic [NUM_DIG-1:0]     blank_mask,
  input  logic [NUM_DIG-1:0]     blink_mask,
  input  logic [3:0]             bright,
  input  logic                   load,
  output logic                   load_ack,
  output logic                   frame_start,
  output logic [NUM_DIG-1:0]     led_en,
  output logic [7:0]             led_cx
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIG);
  localparam int unsigned FrmW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GuardVal = CntW'(GUARD);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_DIG - 1);
  localparam logic [FrmW-1:0] FrmMax   = FrmW'(BLINK_DIV - 1);

  // Scan timing state
  logic [CntW-1:0]        r_cnt;
  logic [IdxW-1:0]        r_idx;
  logic [3:0]             r_pwm;
  logic [FrmW-1:0]        r_frm;
  logic                   r_blink_phase;
  logic                   r_frame_start;

  // Staging and active display sets
  logic [NUM_DIG*8-1:0]   r_stg_disp;
  logic [NUM_DIG-1:0]     r_stg_blank;
  logic [NUM_DIG-1:0]     r_stg_blink;
  logic [NUM_DIG*8-1:0]   r_act_disp;
  logic [NUM_DIG-1:0]     r_act_blank;
  logic [NUM_DIG-1:0]     r_act_blink;
  logic                   r_pend;
  logic                   r_ack;

  // Registered outputs
  logic [NUM_DIG-1:0]     r_led_en;
  logic [7:0]             r_led_cx;

  // Combinational next-state
  logic                   w_tick;
  logic                   w_boundary;
  logic                   w_commit;
  logic [CntW-1:0]        w_cnt_nxt;
  logic [IdxW-1:0]        w_idx_nxt;
  logic [3:0]             w_pwm_nxt;
  logic [FrmW-1:0]        w_frm_nxt;
  logic                   w_phase_nxt;
  logic                   w_pend_nxt;
  logic [7:0]             w_byte;
  logic                   w_blank;
  logic                   w_blink;
  logic [NUM_DIG-1:0]     w_en_lit;
  logic                   w_lit;
  logic [NUM_DIG-1:0]     w_led_en_nxt;
  logic [7:0]             w_led_cx_nxt;

  assign w_tick     = (r_cnt == CntMax);
  assign w_boundary = w_tick && (r_idx == IdxMax);
  assign w_commit   = w_boundary && r_pend;

  always_comb begin
    w_cnt_nxt   = w_tick ? '0 : r_cnt + CntW'(1);
    w_idx_nxt   = r_idx;
    w_frm_nxt   = r_frm;
    w_phase_nxt = r_blink_phase;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IdxMax) ? '0 : r_idx + IdxW'(1);
    end
    if (w_boundary) begin
      if (r_frm == FrmMax) begin
        w_frm_nxt   = '0;
        w_phase_nxt = ~r_blink_phase;
      end else begin
        w_frm_nxt = r_frm + FrmW'(1);
      end
    end
    // PWM restarts at every slot so each digit gets the same duty pattern.
    if (w_tick || r_pwm == 4'd14) begin
      w_pwm_nxt = 4'd0;
    end else begin
      w_pwm_nxt = r_pwm + 4'd1;
    end
  end

  // A load coinciding with a commit lands in staging after the old staging moved to active.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_commit) begin
      w_pend_nxt = 1'b0;
    end
    if (load) begin
      w_pend_nxt = 1'b1;
    end
  end

  // Select the active byte and mask bits for the current digit; digit i lives in the
  // (NUM_DIG-1-i) position of every packed vector.
  always_comb begin
    w_byte   = 8'hFF;
    w_blank  = 1'b1;
    w_blink  = 1'b0;
    w_en_lit = '1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_byte                 = r_act_disp[(NUM_DIG-1-i)*8 +: 8];
        w_blank                = r_act_blank[NUM_DIG-1-i];
        w_blink                = r_act_blink[NUM_DIG-1-i];
        w_en_lit[NUM_DIG-1-i]  = 1'b0;
      end
    end
  end

  always_comb begin
    w_lit = (r_cnt >= GuardVal) &&
            ((bright == 4'hF) || (r_pwm < bright)) &&
            !w_blank &&
            !(r_blink_phase && w_blink);
    w_led_en_nxt = '1;
    w_led_cx_nxt = 8'hFF;
    if (w_lit) begin
      w_led_en_nxt = w_en_lit;
      w_led_cx_nxt = w_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pwm         <= '0;
      r_frm         <= '0;
      r_blink_phase <= 1'b0;
      r_frame_start <= 1'b0;
      r_stg_disp    <= '1;
      r_stg_blank   <= '1;
      r_stg_blink   <= '0;
      r_act_disp    <= '1;
      r_act_blank   <= '1;
      r_act_blink   <= '0;
      r_pend        <= 1'b0;
      r_ack         <= 1'b0;
      r_led_en      <= '1;
      r_led_cx      <= 8'hFF;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_pwm         <= w_pwm_nxt;
      r_frm         <= w_frm_nxt;
      r_blink_phase <= w_phase_nxt;
      r_frame_start <= w_boundary;
      r_pend        <= w_pend_nxt;
      r_ack         <= w_commit;
      r_led_en      <= w_led_en_nxt;
      r_led_cx      <= w_led_cx_nxt;
      if (w_commit) begin
        r_act_disp  <= r_stg_disp;
        r_act_blank <= r_stg_blank;
        r_act_blink <= r_stg_blink;
      end
      if (load) begin
        r_stg_disp  <= display_in;
        r_stg_blank <= blank_mask;
        r_stg_blink <= blink_mask;
      end
    end
  end

  assign load_ack    = r_ack;
  assign frame_start = r_frame_start;
  assign led_en      = r_led_en;
  assign led_cx      = r_led_cx;

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL take parameter NUM_DIG, default 8: number of digits scanned, legal range 2..8.
REQ-002 SHALL take parameter SCAN_DIV, default 100000: clocks per digit slot, legal minimum 16.
REQ-003 SHALL take parameter GUARD, default 2: dark anti-ghost clocks at the start of each slot, legal range 0..SCAN_DIV-1.
REQ-004 SHALL take parameter BLINK_DIV, default 250: frames per blink half-period, legal minimum 1.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port display_in  in  NUM_DIG*8  segment bytes, active-low; digit 0 is the most significant byte.
REQ-008 SHALL have port blank_mask  in  NUM_DIG  digit forced dark; bit NUM_DIG-1 maps to digit 0.
REQ-009 SHALL have port blink_mask  in  NUM_DIG  digit blinks; same bit mapping as blank_mask.
REQ-010 SHALL have port bright  in  4  brightness duty, 0 = off, 15 = always on; sampled live.
REQ-011 SHALL have port load  in  1  request to capture display_in, blank_mask and blink_mask into staging.
REQ-012 SHALL have port load_ack  out  1  one-clock pulse when staging is committed to the active set.
REQ-013 SHALL have port frame_start  out  1  one-clock pulse when the digit index wraps to 0.
REQ-014 SHALL have port led_en  out  NUM_DIG  digit enables, active-low; bit NUM_DIG-1 maps to digit 0.
REQ-015 SHALL have port led_cx  out  8  segments, active-low; 8'hFF = all off.

Function
REQ-016 SHALL count cnt 0..SCAN_DIV-1, wrapping to 0; tick = (cnt == SCAN_DIV-1).
REQ-017 SHALL advance digit index idx on tick, wrapping NUM_DIG-1 -> 0; boundary = tick with idx == NUM_DIG-1.
REQ-018 SHALL pulse frame_start for one clock in the cycle after each boundary.
REQ-019 SHALL run a pwm counter 0..14, wrapping, that is forced to 0 on tick.
REQ-020 SHALL count frames 0..BLINK_DIV-1 on each boundary and toggle blink_phase when the count wraps.
REQ-021 SHALL treat the digit as lit when all hold: cnt >= GUARD, pwm < bright (bright 15 = always lit), active blank bit for idx = 0, and not (blink_phase = 1 with active blink bit for idx = 1).
REQ-022 SHALL register led_en and led_cx with one clock of latency from cnt, idx and pwm.
REQ-023 SHALL drive, when lit, only led_en bit (NUM_DIG-1-idx) low and led_cx = active byte idx.
REQ-024 SHALL drive, when not lit, led_en all ones and led_cx = 8'hFF.
REQ-025 SHALL capture the load inputs into staging in any cycle where load = 1 and set pending; a later load before commit overwrites staging (latest wins).
REQ-026 SHALL, on a boundary with pending = 1, copy staging to active, clear pending and pulse load_ack in the next cycle.
REQ-027 SHALL, when load and a committing boundary coincide, commit the prior staging, capture the new inputs into staging and leave pending = 1.
REQ-028 SHALL hold load_ack at 0 except for the commit pulse; a load while idle with no pending request SHALL NOT ack until the next boundary.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force: cnt, idx, pwm, frame count, blink_phase and pending = 0; staging and active display bytes = 8'hFF; staging and active blank_mask = all ones; blink masks = 0; led_en all ones; led_cx = 8'hFF; load_ack = 0; frame_start = 0.
REQ-030 SHALL resume counting from cnt = 0, idx = 0 on the first clock after rst_n rises.

Verification
REQ-031 SHALL cover reset and idle with NUM_DIG=4, SCAN_DIV=8, GUARD=2, BLINK_DIV=2 -> led_en = 4'hF and led_cx = 8'hFF both during and after reset with no load; frame_start every 32 clocks.
REQ-032 SHALL cover a single load of display_in=32'hC0F9A4B0 with masks 0 and bright=15 -> exactly one load_ack at the first boundary; in each digit-0 slot led_en = 4'b0111 and led_cx = 8'hC0 for 6 clocks and dark for 2.
REQ-033 SHALL cover brightness: bright=4 -> 2 lit clocks per slot; bright=0 -> never lit.
REQ-034 SHALL cover blink: blink_mask=4'b1000 -> digit 0 lit in frames 0-1, dark in frames 2-3, repeating, while other digits are unaffected.
REQ-035 SHALL cover load ordering: two loads in one frame -> only the second data is shown, with a single ack; a load coincident with a committing boundary -> two acks on consecutive boundaries, in order.
REQ-036 SHALL cover rst_n pulsed mid-slot with a load pending -> outputs dark in the same cycle, pending discarded, and no load_ack after release.
